// File: rtl/sb_tx_msg_arbiter.sv
// Round-robin owner of the sideband TX message channel.
// Latches one requester's message, strobes it out, waits for completion or timeout.
module sb_tx_msg_arbiter #(
    parameter int N_REQ       = 2,
    parameter int MSG_W       = 4,
    parameter int INFO_W      = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*MSG_W-1:0]  i_msg,
    input  logic [N_REQ*INFO_W-1:0] i_info,
    input  logic                    i_falling_edge_busy,
    output logic [MSG_W-1:0]        o_TX_SbMessage,
    output logic [INFO_W-1:0]       o_msg_info,
    output logic                    o_msg_valid,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_ack,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ACK
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;

    // Closest requester after the last winner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int d = 0; d < N_REQ; d++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!pick_found && i_req[k] &&
                    (k == (int'(rr_ptr) + 1 + d) % N_REQ)) begin
                    pick_found = 1'b1;
                    pick_idx   = PTR_W'(k);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= PTR_INIT;
            cnt            <= '0;
            o_TX_SbMessage <= '0;
            o_msg_info     <= '0;
            o_msg_valid    <= 1'b0;
            o_grant        <= '0;
            o_ack          <= '0;
            o_busy         <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_msg_valid <= 1'b0;
            o_ack       <= '0;
            o_timeout   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        o_TX_SbMessage <= i_msg[pick_idx*MSG_W +: MSG_W];
                        o_msg_info     <= i_info[pick_idx*INFO_W +: INFO_W];
                        o_grant        <= GNT_ONE << pick_idx;
                        rr_ptr         <= pick_idx;
                        o_msg_valid    <= 1'b1;
                        o_busy         <= 1'b1;
                        cnt            <= '0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_falling_edge_busy) begin
                        o_ack   <= o_grant;
                        o_grant <= '0;
                        state   <= ACK;
                    end else begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Completion beats expiry when both land together.
                    if (i_falling_edge_busy) begin
                        o_ack   <= o_grant;
                        o_grant <= '0;
                        cnt     <= '0;
                        state   <= ACK;
                    end else if (cnt == CNT_LAST) begin
                        o_timeout <= 1'b1;
                        o_grant   <= '0;
                        o_busy    <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    o_busy <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
